// File: rtl/hdmi_rd_pkg.sv
// Shared types and constants for the HDMI burst reader.
package hdmi_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        DATA,
        CMPLT
    } rd_state_t;

    function automatic int burst_bytes(input int beats, input int dwidth);
        return beats * dwidth / 8;
    endfunction

    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hdmi_rd_credit.sv
// Up/down saturating FIFO credit counter; "enough" looks at the next value so a
// waiting burst can issue in the same cycle its final credit lands.
module hdmi_rd_credit #(
    parameter int C_FIFO_DEPTH  = 128,
    parameter int C_BURST_BEATS = 16,
    parameter int CW            = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          take,
    input  logic          give,
    output logic [CW-1:0] credits,
    output logic          enough
);

    localparam logic [CW:0]   DEPTH_W = (CW+1)'(C_FIFO_DEPTH);
    localparam logic [CW:0]   BEATS_W = (CW+1)'(C_BURST_BEATS);
    localparam logic [CW-1:0] DEPTH_C = CW'(C_FIFO_DEPTH);

    logic [CW:0]   sum;
    logic [CW-1:0] credits_next;

    always_comb begin
        sum = {1'b0, credits} + {{CW{1'b0}}, give};
        if (take) begin
            sum = (sum >= BEATS_W) ? (sum - BEATS_W) : '0;
        end
        credits_next = (sum > DEPTH_W) ? DEPTH_C : sum[CW-1:0];
        enough       = ({1'b0, credits_next} >= BEATS_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= DEPTH_C;
        end else begin
            credits <= credits_next;
        end
    end

endmodule

// File: rtl/hdmi_burst_reader.sv
// IPIF master burst-read sequencer feeding the HDMI pixel FIFO, credit-gated.
// Optional beat-count checking is compiled in with HDMI_BURST_BEAT_CHECK_EN.
module hdmi_burst_reader
    import hdmi_rd_pkg::*;
#(
    parameter int C_DWIDTH      = 32,
    parameter int C_BURST_BEATS = 16,
    parameter int C_FIFO_DEPTH  = 128,
    parameter int C_LEN_WIDTH   = 12
) (
    input  logic                   Bus2IP_Clk,
    input  logic                   Bus2IP_Resetn,
    input  logic                   go_fill_fifo,
    input  logic [31:0]            ddr_addr_to_read,
    input  logic                   fifo_read,
    output logic                   ip2bus_mstrd_req,
    output logic [31:0]            ip2bus_mst_addr,
    output logic [C_LEN_WIDTH-1:0] ip2bus_mst_length,
    input  logic                   bus2ip_mst_cmdack,
    input  logic                   bus2ip_mst_cmplt,
    input  logic                   bus2ip_mst_error,
    input  logic [C_DWIDTH-1:0]    bus2ip_mstrd_d,
    input  logic                   bus2ip_mstrd_src_rdy_n,
    input  logic                   bus2ip_mstrd_eof_n,
    output logic                   ip2bus_mstrd_dst_rdy_n,
    output logic                   fifo_write,
    output logic [C_DWIDTH-1:0]    fifo_data,
    output logic                   busy,
    output logic                   err,
    output logic                   overrun
);

    localparam int                     CW  = credit_width(C_FIFO_DEPTH);
    localparam logic [C_LEN_WIDTH-1:0] LEN = C_LEN_WIDTH'(burst_bytes(C_BURST_BEATS, C_DWIDTH));

    rd_state_t     state;
    logic [31:0]   addr;
    logic [31:0]   pend_addr;
    logic          pend_vld;
    logic [CW-1:0] credits;
    logic          enough;
    logic          take;
    logic          accept;
    logic          eof_beat;
    logic          finish;
    logic          beat_err;

    assign take     = (state == REQ) && bus2ip_mst_cmdack;
    assign accept   = !bus2ip_mstrd_src_rdy_n && !ip2bus_mstrd_dst_rdy_n;
    assign eof_beat = accept && !bus2ip_mstrd_eof_n;
    assign finish   = ((state == DATA) || (state == CMPLT)) && bus2ip_mst_cmplt;

    assign ip2bus_mst_addr   = addr;
    assign ip2bus_mst_length = LEN;
    assign busy              = (state != IDLE) || pend_vld;

    hdmi_rd_credit #(
        .C_FIFO_DEPTH (C_FIFO_DEPTH),
        .C_BURST_BEATS(C_BURST_BEATS),
        .CW           (CW)
    ) u_credit (
        .clk    (Bus2IP_Clk),
        .rst_n  (Bus2IP_Resetn),
        .take   (take),
        .give   (fifo_read),
        .credits(credits),
        .enough (enough)
    );

`ifdef HDMI_BURST_BEAT_CHECK_EN
    localparam logic [CW-1:0] BEATS_C = CW'(C_BURST_BEATS);

    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_next;

    // Counter holds at all-ones so runaway extra beats cannot wrap back to a legal count.
    assign beat_cnt_next = (accept && !(&beat_cnt)) ? beat_cnt + 1'b1 : beat_cnt;
    assign beat_err      = (eof_beat && (beat_cnt_next != BEATS_C))
                         || (finish && (beat_cnt_next < BEATS_C));

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            beat_cnt <= '0;
        end else if ((state == IDLE) || (state == WAIT_SPACE)) begin
            beat_cnt <= '0;
        end else begin
            beat_cnt <= beat_cnt_next;
        end
    end
`else
    assign beat_err = 1'b0;
`endif

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state                  <= IDLE;
            ip2bus_mstrd_req       <= 1'b0;
            ip2bus_mstrd_dst_rdy_n <= 1'b1;
            fifo_write             <= 1'b0;
            fifo_data              <= '0;
            addr                   <= '0;
            pend_addr              <= '0;
            pend_vld               <= 1'b0;
            err                    <= 1'b0;
            overrun                <= 1'b0;
        end else begin
            fifo_write <= accept;
            if (accept) begin
                fifo_data <= bus2ip_mstrd_d;
            end

            if (beat_err || (finish && bus2ip_mst_error)) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (go_fill_fifo) begin
                        addr  <= ddr_addr_to_read;
                        state <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    // Sink is opened with the request so a beat riding on cmdack is taken.
                    if (enough) begin
                        ip2bus_mstrd_req       <= 1'b1;
                        ip2bus_mstrd_dst_rdy_n <= 1'b0;
                        state                  <= REQ;
                    end
                end
                REQ: begin
                    if (bus2ip_mst_cmdack) begin
                        ip2bus_mstrd_req <= 1'b0;
                        state            <= eof_beat ? CMPLT : DATA;
                    end
                end
                DATA, CMPLT: begin
                    if (finish) begin
                        ip2bus_mstrd_dst_rdy_n <= 1'b1;
                        if (pend_vld) begin
                            addr  <= pend_addr;
                            state <= WAIT_SPACE;
                        end else if (go_fill_fifo) begin
                            addr  <= ddr_addr_to_read;
                            state <= WAIT_SPACE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if ((state == DATA) && eof_beat) begin
                        state <= CMPLT;
                    end
                end
                default: state <= IDLE;
            endcase

            // A request that lands on the finishing cycle with an empty slot goes straight to addr.
            if (go_fill_fifo && (state != IDLE) && !(finish && !pend_vld)) begin
                if (!pend_vld || finish) begin
                    pend_vld  <= 1'b1;
                    pend_addr <= ddr_addr_to_read;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (finish && pend_vld) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_burst_reader.sv
// Scoreboard bench for hdmi_burst_reader: a bus model serves bursts, a monitor checks FIFO writes.
module tb_hdmi_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [31:0] ddr_addr = '0;
    logic        fifo_read = 1'b0;
    logic        req;
    logic [31:0] mst_addr;
    logic [11:0] mst_len;
    logic        cmdack = 1'b0;
    logic        cmplt = 1'b0;
    logic        mst_error = 1'b0;
    logic [31:0] rd_d = '0;
    logic        src_rdy_n = 1'b1;
    logic        eof_n = 1'b1;
    logic        dst_rdy_n;
    logic        fifo_write;
    logic [31:0] fifo_data;
    logic        busy;
    logic        err;
    logic        overrun;

    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    logic [31:0] exp_q[$];

    hdmi_burst_reader dut (
        .Bus2IP_Clk            (clk),
        .Bus2IP_Resetn         (rst_n),
        .go_fill_fifo          (go),
        .ddr_addr_to_read      (ddr_addr),
        .fifo_read             (fifo_read),
        .ip2bus_mstrd_req      (req),
        .ip2bus_mst_addr       (mst_addr),
        .ip2bus_mst_length     (mst_len),
        .bus2ip_mst_cmdack     (cmdack),
        .bus2ip_mst_cmplt      (cmplt),
        .bus2ip_mst_error      (mst_error),
        .bus2ip_mstrd_d        (rd_d),
        .bus2ip_mstrd_src_rdy_n(src_rdy_n),
        .bus2ip_mstrd_eof_n    (eof_n),
        .ip2bus_mstrd_dst_rdy_n(dst_rdy_n),
        .fifo_write            (fifo_write),
        .fifo_data             (fifo_data),
        .busy                  (busy),
        .err                   (err),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && fifo_write) begin
            wr_count++;
            chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                chk("wr_data", 64'(fifo_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_go(input logic [31:0] a);
        go       = 1'b1;
        ddr_addr = a;
        tick();
        go = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req && n < 50) begin
            tick();
            n++;
        end
        chk("req_seen", 64'(req), 64'd1);
    endtask

    // Serves one burst: command handshake, beats, then cmplt; optional go pulses on chosen beats.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] base, input int nbeats,
                         input logic with_err, input int ga_beat, input logic [31:0] ga_addr,
                         input int gb_beat, input logic [31:0] gb_addr);
        wait_req();
        chk("cmd_addr", 64'(mst_addr), 64'(exp_addr));
        chk("cmd_len", 64'(mst_len), 64'd64);
        tick();
        tick();
        chk("req_held", 64'(req), 64'd1);
        cmdack = 1'b1;
        tick();
        cmdack = 1'b0;
        chk("req_drop", 64'(req), 64'd0);
        for (int i = 0; i < nbeats; i++) begin
            go        = (i == ga_beat) || (i == gb_beat);
            ddr_addr  = (i == ga_beat) ? ga_addr : gb_addr;
            src_rdy_n = 1'b0;
            rd_d      = base + 32'(i);
            eof_n     = (i == nbeats - 1) ? 1'b0 : 1'b1;
            exp_q.push_back(base + 32'(i));
            tick();
        end
        go        = 1'b0;
        src_rdy_n = 1'b1;
        eof_n     = 1'b1;
        cmplt     = 1'b1;
        mst_error = with_err;
        tick();
        cmplt     = 1'b0;
        mst_error = 1'b0;
        tick();
    endtask

    initial begin
        int w0;
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;

        // Reset state
        tick();
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_dst_rdy_n", 64'(dst_rdy_n), 64'd1);
        chk("rst_fifo_write", 64'(fifo_write), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_credits", 64'(dut.credits), 64'd128);
        rst_n = 1'b1;
        tick();

        // Single burst
        w0 = wr_count;
        do_go(32'h8000_0000);
        serve(32'h8000_0000, 32'd0, 16, 1'b0, -1, '0, -1, '0);
        chk("single_writes", 64'(wr_count - w0), 64'd16);
        chk("single_credits", 64'(dut.credits), 64'd112);
        chk("single_busy", 64'(busy), 64'd0);
        chk("single_err", 64'(err), 64'd0);

        // Credit stall
        do_reset();
        for (int b = 0; b < 8; b++) begin
            do_go(32'h8000_0000 + 32'(b * 64));
            serve(32'h8000_0000 + 32'(b * 64), 32'(b * 256), 16, 1'b0, -1, '0, -1, '0);
        end
        chk("stall_credits0", 64'(dut.credits), 64'd0);
        do_go(32'h9000_0000);
        repeat (4) tick();
        chk("stall_req_low", 64'(req), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        for (int r = 0; r < 15; r++) begin
            fifo_read = 1'b1;
            tick();
            fifo_read = 1'b0;
        end
        tick();
        chk("stall_15_req", 64'(req), 64'd0);
        fifo_read = 1'b1;
        tick();
        fifo_read = 1'b0;
        chk("stall_16_req", 64'(req), 64'd1);
        serve(32'h9000_0000, 32'h0000_5000, 16, 1'b0, -1, '0, -1, '0);
        chk("stall_done_busy", 64'(busy), 64'd0);

        // Back-to-back requests with one dropped
        do_reset();
        w0 = wr_count;
        do_go(32'h8000_0000);
        serve(32'h8000_0000, 32'h100, 16, 1'b0, 2, 32'h8000_0040, 6, 32'h8000_0080);
        chk("b2b_overrun", 64'(overrun), 64'd1);
        serve(32'h8000_0040, 32'h200, 16, 1'b0, -1, '0, -1, '0);
        repeat (3) tick();
        chk("b2b_idle_req", 64'(req), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd0);
        chk("b2b_writes", 64'(wr_count - w0), 64'd32);
        chk("b2b_credits", 64'(dut.credits), 64'd96);

        // Bus error is sticky; following burst proceeds
        do_reset();
        w0 = wr_count;
        do_go(32'h8000_1000);
        serve(32'h8000_1000, 32'h300, 16, 1'b1, -1, '0, -1, '0);
        chk("err_set", 64'(err), 64'd1);
        do_go(32'h8000_1040);
        serve(32'h8000_1040, 32'h400, 16, 1'b0, -1, '0, -1, '0);
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_writes", 64'(wr_count - w0), 64'd32);
        chk("err_busy", 64'(busy), 64'd0);

        // Reset in the middle of a burst
        do_reset();
        do_go(32'h8000_2000);
        wait_req();
        cmdack = 1'b1;
        tick();
        cmdack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            src_rdy_n = 1'b0;
            rd_d      = 32'h600 + 32'(i);
            exp_q.push_back(32'h600 + 32'(i));
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(req), 64'd0);
        chk("mid_rst_dst_rdy_n", 64'(dst_rdy_n), 64'd1);
        chk("mid_rst_fifo_write", 64'(fifo_write), 64'd0);
        chk("mid_rst_credits", 64'(dut.credits), 64'd128);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        src_rdy_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();

        // Short burst: eof on beat 10
        w0 = wr_count;
        do_go(32'h8000_3000);
        serve(32'h8000_3000, 32'h700, 10, 1'b0, -1, '0, -1, '0);
        chk("short_writes", 64'(wr_count - w0), 64'd10);
        chk("short_busy", 64'(busy), 64'd0);
`ifdef HDMI_BURST_BEAT_CHECK_EN
        chk("short_err", 64'(err), 64'd1);
`else
        chk("short_err", 64'(err), 64'd0);
`endif
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
